move_cmd_gen: RTL

- Upstream front end of the adventure room state machine.
- Turns four raw, asynchronous direction buttons into clean one-cycle n/s/e/w move commands.
- Keeps the sticky sword-held (v) and wizard-met (h) qualifiers that the dragon-den decision consumes.
- Counts accepted moves for the score display.

---
 rtl/move_cmd_gen.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/move_cmd_gen.sv
// move_cmd_gen: front end of the adventure room state machine.
// Synchronizes and debounces the four direction buttons, issues one-cycle
// n/s/e/w move commands, holds the sticky sword (v) and wizard (h) flags and
// counts accepted moves with saturation.
// Optional build macro MOVE_CMD_REPEAT_EN adds auto-repeat of a held direction
// every REPEAT_CYCLES clocks; when undefined, one pulse is issued per press.
module move_cmd_gen #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned MOVE_W        = 8,
  parameter int unsigned REPEAT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_n,
  input  logic              btn_s,
  input  logic              btn_e,
  input  logic              btn_w,
  input  logic              sw_in,
  input  logic              wz_in,
  input  logic              restart,
  output logic              n,
  output logic              s,
  output logic              e,
  output logic              w,
  output logic              v,
  output logic              h,
  output logic [MOVE_W-1:0] moves
);

  localparam int unsigned NB   = 4;
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RELEASE
  } state_t;

  // Button bit order: 0 = north, 1 = south, 2 = east, 3 = west.
  logic [NB-1:0]   w_raw;
  logic [NB-1:0]   r_sync1;
  logic [NB-1:0]   r_sync2;
  logic [NB-1:0]   r_deb;
  logic [DB_W-1:0] r_db_cnt [NB];

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NB-1:0]   r_cmd;
  logic [NB-1:0]   w_cmd_nxt;
  logic            w_issue;
  logic            w_deb_any;
  logic            w_deb_one;

  logic            r_v;
  logic            r_h;
  logic [MOVE_W-1:0] r_moves;

  assign w_raw = {btn_w, btn_e, btn_s, btn_n};

  // Two-flop synchronizers followed by per-button stability counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < NB; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_deb[i]    <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_deb_any = |r_deb;
  assign w_deb_one = w_deb_any && ((r_deb & (r_deb - NB'(1))) == '0);

`ifdef MOVE_CMD_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 2);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_ok;
  logic [NB-1:0]    r_last;
  logic             w_rep_fire;

  // Repeat fires once the held set has matched the last direction long enough
  // that the new ISSUE lands exactly REPEAT_CYCLES after the previous one.
  assign w_rep_fire = r_rep_ok && (r_deb == r_last) && (r_rep_cnt == REP_LAST);

  // Repeat timer: armed by each issued command, dropped by any set change.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_rep_cnt <= '0;
      r_rep_ok  <= 1'b0;
    end else if (w_issue) begin
      r_rep_cnt <= '0;
      r_rep_ok  <= 1'b1;
    end else if (r_state == ST_WAIT_RELEASE) begin
      if (r_rep_ok && (r_deb == r_last)) begin
        r_rep_cnt <= r_rep_cnt + REP_W'(1);
      end else begin
        r_rep_cnt <= '0;
        r_rep_ok  <= 1'b0;
      end
    end else begin
      r_rep_cnt <= '0;
    end
  end

  // Last issued direction, compared against the held set for repeating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= '0;
    end else if (w_issue) begin
      r_last <= w_cmd_nxt;
    end
  end
`endif

  // Command FSM next state; restart overrides everything to WAIT_RELEASE.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = '0;
    w_issue     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_deb_one) begin
          w_state_nxt = ST_ISSUE;
          w_cmd_nxt   = r_deb;
          w_issue     = 1'b1;
        end else if (w_deb_any) begin
          w_state_nxt = ST_WAIT_RELEASE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (!w_deb_any) begin
          w_state_nxt = ST_IDLE;
        end
`ifdef MOVE_CMD_REPEAT_EN
        else if (w_rep_fire) begin
          w_state_nxt = ST_ISSUE;
          w_cmd_nxt   = r_last;
          w_issue     = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_WAIT_RELEASE;
      end
    endcase
    if (restart) begin
      w_state_nxt = ST_WAIT_RELEASE;
      w_cmd_nxt   = '0;
      w_issue     = 1'b0;
    end
  end

  // FSM state and the registered one-hot command held during ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_WAIT_RELEASE;
      r_cmd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
    end
  end

  // Sticky qualifiers; restart wins over a same-cycle set request.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_v <= 1'b0;
      r_h <= 1'b0;
    end else begin
      if (sw_in) r_v <= 1'b1;
      if (wz_in) r_h <= 1'b1;
    end
  end

  // Saturating count of accepted moves.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_moves <= '0;
    end else if (w_issue && (r_moves != '1)) begin
      r_moves <= r_moves + MOVE_W'(1);
    end
  end

  assign n     = r_cmd[0];
  assign s     = r_cmd[1];
  assign e     = r_cmd[2];
  assign w     = r_cmd[3];
  assign v     = r_v;
  assign h     = r_h;
  assign moves = r_moves;

endmodule
